inst_loader: RTL and testbench

Program-load controller for the writable instruction memory of the single-cycle CPU. It accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit instructions and writes them to consecutive word addresses starting at 0. It owns the instruction memory address/write port and hands it back to the CPU fetch path when the load completes. It stalls the CPU during the load and requests a PC reset at the end.

---
 rtl/inst_loader_pkg.sv | 23 ++
 rtl/inst_word_packer.sv | 43 ++++
 rtl/inst_loader.sv | 118 +++++++++++
 tb/tb_inst_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared widths, loader state encoding and the load-length clamp helper.
// Imported by the loader top and its word packer.
package inst_loader_pkg;

    localparam int ADDR_LEN   = 32;
    localparam int INSTR_LEN  = 32;
    localparam int LD_CNT_LEN = 9;

    typedef enum logic [1:0] {
        LD_RUN   = 2'd0,
        LD_RECV  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_t;

    function automatic logic [LD_CNT_LEN-1:0] clamp_len(
        input logic [LD_CNT_LEN-1:0] len,
        input logic [LD_CNT_LEN-1:0] max_len
    );
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/inst_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; full flags the 4th accepted byte.
// Single-cycle shift, no backpressure of its own (the caller gates shift).
module inst_word_packer
    import inst_loader_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 shift_i,
    input  logic [7:0]           byte_in_i,
    output logic [INSTR_LEN-1:0] word_out_o,
    output logic                 full_o
);

    logic [INSTR_LEN-1:0] word_q, word_d;
    logic [1:0]           cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else if (shift_i) begin
            word_d = {word_q[INSTR_LEN-9:0], byte_in_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // The counter wraps to 0 on the 4th byte, so the next word starts clean.
    assign full_o     = shift_i && !clr_i && (cnt_q == 2'd3);
    assign word_out_o = word_q;

endmodule

// File: rtl/inst_loader.sv
// Program-load controller: streams bytes into instruction memory words 0..N-1,
// stalls the CPU meanwhile and requests a PC reset when the load completes.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_start_i,
    input  logic [LD_CNT_LEN-1:0] load_len_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_ready_o,
    input  logic [ADDR_LEN-1:0]   cpu_addr_i,
    output logic [ADDR_LEN-1:0]   imem_addr_o,
    output logic                  imem_we_o,
    output logic [INSTR_LEN-1:0]  imem_wdata_o,
    output logic                  cpu_stall_o,
    output logic                  cpu_rst_req_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LD_CNT_LEN-1:0] word_cnt_o
);

    localparam logic [LD_CNT_LEN-1:0] MAX_LEN = LD_CNT_LEN'(DEPTH);

    ld_state_t             state_q, state_d;
    logic [LD_CNT_LEN-1:0] word_cnt_q, word_cnt_d;
    logic [LD_CNT_LEN-1:0] len_q, len_d;
    logic                  zero_done_q, zero_done_d;
    logic                  pk_clr, pk_shift, pk_full;
    logic [INSTR_LEN-1:0]  pk_word;

    assign pk_shift = rx_valid_i && (state_q == LD_RECV);

    inst_word_packer u_packer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (pk_clr),
        .shift_i    (pk_shift),
        .byte_in_i  (rx_data_i),
        .word_out_o (pk_word),
        .full_o     (pk_full)
    );

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        len_d         = len_q;
        zero_done_d   = 1'b0;
        pk_clr        = 1'b0;
        imem_addr_o   = cpu_addr_i;
        imem_we_o     = 1'b0;
        rx_ready_o    = 1'b0;
        cpu_stall_o   = 1'b0;
        cpu_rst_req_o = 1'b0;
        busy_o        = 1'b0;
        done_o        = zero_done_q;
        unique case (state_q)
            LD_RUN: begin
                if (load_start_i) begin
                    word_cnt_d = '0;
                    if (load_len_i != '0) begin
                        len_d   = clamp_len(load_len_i, MAX_LEN);
                        pk_clr  = 1'b1;
                        state_d = LD_RECV;
                    end else begin
                        // Empty load: report completion but leave the CPU running.
                        zero_done_d = 1'b1;
                    end
                end
            end
            LD_RECV: begin
                rx_ready_o  = 1'b1;
                cpu_stall_o = 1'b1;
                busy_o      = 1'b1;
                if (pk_full) begin
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                cpu_stall_o = 1'b1;
                busy_o      = 1'b1;
                imem_we_o   = 1'b1;
                imem_addr_o = ADDR_LEN'({word_cnt_q[7:0], 2'b00});
                word_cnt_d  = word_cnt_q + 1'b1;
                state_d     = (word_cnt_d == len_q) ? LD_DONE : LD_RECV;
            end
            LD_DONE: begin
                cpu_stall_o   = 1'b1;
                busy_o        = 1'b1;
                cpu_rst_req_o = 1'b1;
                done_o        = 1'b1;
                state_d       = LD_RUN;
            end
            default: state_d = LD_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= LD_RUN;
            word_cnt_q  <= '0;
            len_q       <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            zero_done_q <= zero_done_d;
        end
    end

    assign imem_wdata_o = pk_word;
    assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: single word, gapped stream, empty load,
// interruptions, full-depth and clamped loads.
module tb_inst_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        load_start_i;
    logic [8:0]  load_len_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic [31:0] cpu_addr_i;
    logic [31:0] imem_addr_o;
    logic        imem_we_o;
    logic [31:0] imem_wdata_o;
    logic        cpu_stall_o;
    logic        cpu_rst_req_o;
    logic        busy_o;
    logic        done_o;
    logic [8:0]  word_cnt_o;

    inst_loader #(.DEPTH(256)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .load_start_i  (load_start_i),
        .load_len_i    (load_len_i),
        .rx_valid_i    (rx_valid_i),
        .rx_data_i     (rx_data_i),
        .rx_ready_o    (rx_ready_o),
        .cpu_addr_i    (cpu_addr_i),
        .imem_addr_o   (imem_addr_o),
        .imem_we_o     (imem_we_o),
        .imem_wdata_o  (imem_wdata_o),
        .cpu_stall_o   (cpu_stall_o),
        .cpu_rst_req_o (cpu_rst_req_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .word_cnt_o    (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Write/done monitor, sampled on the falling edge.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_n;
    int          rst_req_n;
    logic [8:0]  done_wcnt;

    always @(negedge clk_i) begin
        if (imem_we_o) begin
            wr_addr.push_back(imem_addr_o);
            wr_data.push_back(imem_wdata_o);
        end
        if (done_o) begin
            done_n++;
            done_wcnt = word_cnt_o;
        end
        if (cpu_rst_req_o) rst_req_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic mon_clear();
        wr_addr.delete();
        wr_data.delete();
        done_n    = 0;
        rst_req_n = 0;
        done_wcnt = '0;
    endtask

    task automatic start(input logic [8:0] len);
        load_start_i = 1'b1;
        load_len_i   = len;
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        for (int i = 0; i < 40; i++) begin
            if (rx_ready_o) begin
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        rx_valid_i = 1'b0;
        if (!ok) chk("rx_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int b = 0; b < 4; b++) begin
            int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) tick();
            send_byte(w[31 - 8*b -: 8]);
        end
    endtask

    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] iv;
        iv = i[7:0];
        return {iv, 8'hA5, ~iv, 8'h3C};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w3[3];
        int          t0;
        int          err;
        w3[0] = 32'h0000_0000;
        w3[1] = 32'h1122_3344;
        w3[2] = 32'hFFFF_FFFF;

        rst_i        = 1'b1;
        load_start_i = 1'b0;
        load_len_i   = '0;
        rx_valid_i   = 1'b0;
        rx_data_i    = '0;
        cpu_addr_i   = 32'h0000_000C;
        mon_clear();
        repeat (2) tick();
        rst_i = 1'b0;

        // Reset state
        chk("rst_imem_addr", imem_addr_o, 32'h0000_000C);
        chk("rst_imem_we",   imem_we_o, 0);
        chk("rst_rx_ready",  rx_ready_o, 0);
        chk("rst_stall",     cpu_stall_o, 0);
        chk("rst_word_cnt",  word_cnt_o, 0);
        chk("rst_wdata",     imem_wdata_o, 0);
        chk("rst_busy_done", {busy_o, done_o, cpu_rst_req_o}, 0);
        cpu_addr_i = 32'h0000_0040;
        #1;
        chk("run_addr_mux", imem_addr_o, 32'h0000_0040);

        // Single word, exact cycle timing
        mon_clear();
        start(9'd1);
        chk("w1_rx_ready", rx_ready_o, 1);
        chk("w1_stall",    {cpu_stall_o, busy_o}, 2'b11);
        send_word(32'h2001_0001, 0);
        chk("w1_we",    imem_we_o, 1);
        chk("w1_addr",  imem_addr_o, 0);
        chk("w1_wdata", imem_wdata_o, 32'h2001_0001);
        chk("w1_wr_rdy", rx_ready_o, 0);
        tick();
        chk("w1_done",   {done_o, cpu_rst_req_o, cpu_stall_o, imem_we_o}, 4'b1110);
        tick();
        chk("w1_released", {cpu_stall_o, busy_o, done_o}, 0);
        chk("w1_word_cnt", word_cnt_o, 1);
        chk("w1_writes",   wr_addr.size(), 1);

        // Three words with random valid gaps
        mon_clear();
        start(9'd3);
        for (int i = 0; i < 3; i++) send_word(w3[i], 3);
        wait_done(50);
        tick();
        chk("w3_writes", wr_addr.size(), 3);
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            chk($sformatf("w3_addr%0d", i), wr_addr[i], 32'(i * 4));
            chk($sformatf("w3_data%0d", i), wr_data[i], w3[i]);
        end
        chk("w3_done_wcnt", done_wcnt, 3);
        chk("w3_done_n",    done_n, 1);

        // Empty load
        mon_clear();
        start(9'd0);
        chk("z_done",  {done_o, cpu_rst_req_o, cpu_stall_o, imem_we_o, busy_o}, 5'b10000);
        chk("z_wcnt",  word_cnt_o, 0);
        tick();
        chk("z_done_pulse", done_o, 0);
        chk("z_rst_req_n",  rst_req_n, 0);
        chk("z_writes",     wr_addr.size(), 0);

        // load_start during RECV is ignored
        mon_clear();
        start(9'd2);
        send_byte(8'hDE);
        load_start_i = 1'b1;
        load_len_i   = 9'd5;
        tick();
        load_start_i = 1'b0;
        chk("ign_busy", {busy_o, rx_ready_o}, 2'b11);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_word(32'hCAFE_F00D, 0);
        wait_done(20);
        tick();
        chk("ign_writes", wr_addr.size(), 2);
        if (wr_data.size() == 2) chk("ign_data0", wr_data[0], 32'hDEAD_BEEF);
        chk("ign_wcnt", word_cnt_o, 2);

        // Reset after two bytes of a word
        mon_clear();
        start(9'd2);
        send_byte(8'h12);
        send_byte(8'h34);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_state", {busy_o, rx_ready_o, cpu_stall_o, imem_we_o}, 0);
        repeat (6) tick();
        chk("mid_rst_writes", wr_addr.size(), 0);
        chk("mid_rst_done",   done_n + rst_req_n, 0);

        // load_start colliding with reset
        rst_i = 1'b1;
        start(9'd1);
        rst_i = 1'b0;
        chk("rst_wins", busy_o, 0);

        // Fresh word after a mid-word reset must not inherit stale bytes
        mon_clear();
        start(9'd1);
        send_word(32'hAABB_CCDD, 0);
        chk("post_rst_we",    imem_we_o, 1);
        chk("post_rst_wdata", imem_wdata_o, 32'hAABB_CCDD);
        wait_done(10);
        tick();

        // Full-depth load with latency check
        mon_clear();
        start(9'd256);
        t0 = cyc;
        for (int i = 0; i < 256; i++) send_word(pat(i), 0);
        wait_done(20);
        chk("d256_latency", cyc - t0, 5 * 256);
        tick();
        chk("d256_writes", wr_addr.size(), 256);
        if (wr_addr.size() > 0) chk("d256_last_addr", wr_addr[wr_addr.size()-1], 32'h0000_03FC);
        chk("d256_done_wcnt", done_wcnt, 256);
        err = 0;
        for (int i = 0; i < wr_data.size(); i++)
            if (wr_data[i] !== pat(i) || wr_addr[i] !== 32'(i * 4)) err++;
        chk("d256_data_errs", err, 0);

        // Oversized length is clamped to the memory depth
        mon_clear();
        start(9'd300);
        for (int i = 0; i < 256; i++) send_word(pat(i), 0);
        wait_done(20);
        chk("clamp_done", done_o, 1);
        tick();
        chk("clamp_writes", wr_addr.size(), 256);
        chk("clamp_idle",   busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
